timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, range 1..15: number of compare channels.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 16: prescaler width.
REQ-003 SHALL have localparam ADDR_WIDTH = clog2(16*(CHANNELS+1)): word-aligned byte address width.
REQ-004 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port reset_i, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port csb_i, input, 1: active-low chip select.
REQ-007 SHALL have port wen_i, input, 1: active-low write enable; 1 means read.
REQ-008 SHALL have port addr_i, input, ADDR_WIDTH: byte address; bits [1:0] ignored.
REQ-009 SHALL have port data_i, input, 32: write data.
REQ-010 SHALL have port wmask_i, input, 4: byte-lane write enables.
REQ-011 SHALL have port data_o, output, 32: read data.
REQ-012 SHALL have port irq_o, output, CHANNELS: per-channel interrupt level; bit 0 drives the core's mtip.

Function
REQ-013 SHALL use global map: 0x0 MTIME_LO, 0x4 MTIME_HI, 0x8 PRESCALE, 0xC CTRL (bit0 count enable).
REQ-014 SHALL use per-channel map for channel n at base 0x10+16n: +0 CMP_LO, +4 CMP_HI, +8 RELOAD (32b), +C CHCTRL (bit0 en, bit1 periodic, bit2 pending).
REQ-015 SHALL write a selected register at the edge where csb_i=0 and wen_i=0, updating only lanes with wmask_i[b]=1.
REQ-016 SHALL return read data on data_o one cycle after csb_i=0, wen_i=1 (registered); data_o SHALL be 0 after an unselected, write or unmapped-address cycle.
REQ-017 SHALL ignore writes to unmapped addresses, and to channels >= CHANNELS.
REQ-018 SHALL, with CTRL.bit0=1, increment the PRESCALE_WIDTH-bit prescale counter each cycle, emitting a tick and returning to 0 when it equals PRESCALE; PRESCALE=0 ticks every cycle.
REQ-019 SHALL increment 64-bit mtime by 1 on each tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-020 SHALL hold both the counter and mtime while CTRL.bit0=0.
REQ-021 SHALL, on a write to MTIME_LO/HI, load the written half and suppress that cycle's increment; the other half SHALL be untouched (no carry).
REQ-022 SHALL, on a write to PRESCALE, reset the prescale counter to 0.
REQ-023 SHALL compare mtime >= cmp as 64-bit unsigned, continuously.
REQ-024 SHALL drive one-shot channels (periodic=0) as irq_o[n] = en & (mtime >= cmp), level, no latching.
REQ-025 SHALL, for periodic channels (periodic=1, en=1), in each cycle with mtime >= cmp, set pending and add RELOAD (zero-extended) to cmp mod 2^64.
REQ-026 SHALL drive periodic irq_o[n] = en & pending.
REQ-027 SHALL clear pending by writing 1 to CHCTRL.bit2 (W1C); writing 0 SHALL have no effect.
REQ-028 SHALL, on simultaneous set and W1C of pending, leave pending set.
REQ-029 SHALL, when a CMP write coincides with a periodic match, apply the write, perform no reload that cycle, and still set pending.
REQ-030 SHALL, for periodic RELOAD=0, leave cmp unchanged and hold pending set while matching.
REQ-031 SHALL register irq_o, one cycle after the compare condition.

Reset
REQ-032 SHALL, while reset_i=0, asynchronously set: mtime=0, prescale counter=0, PRESCALE=0, CTRL=0x1, every cmp=0xFFFF_FFFF_FFFF_FFFF, RELOAD=0, CHCTRL=0, data_o=0, irq_o=0.
REQ-033 SHALL, when reset is asserted mid-operation, discard any in-flight read or write.

Structure
REQ-034 SHALL place register offsets, CTRL/CHCTRL bit positions and reset constants in shared package timer_bank_pkg.
REQ-035 SHALL implement each channel (cmp, reload, chctrl, compare, reload adder, irq register) as sub-module timer_channel, instantiated CHANNELS times by generate.
REQ-036 SHALL keep mtime, prescaler, address decode and read mux in timer_bank.

Verification
REQ-037 Reset, then read 0x0/0x4/0xC/0x10/0x14 -> 0, 0, 0x1, 0xFFFFFFFF, 0xFFFFFFFF; irq_o=0.
REQ-038 PRESCALE=3, 40 cycles counting -> MTIME_LO=10.
REQ-039 Ch0 one-shot en, CMP=20, prescale 0 -> irq_o[0] rises at mtime 20, one cycle late; write CMP_HI=1 -> irq_o[0] falls.
REQ-040 Ch1 periodic, CMP=10, RELOAD=10 -> pending at mtime 10; CMP_LO reads 20; W1C clears; re-asserts at mtime 20.
REQ-041 MTIME_LO=0xFFFFFFFF, MTIME_HI=0 written, one tick -> MTIME_HI=1, MTIME_LO=0; write 0x000000AB with wmask=0001 -> MTIME_LO=0xAB.
REQ-042 W1C issued on the same edge as a periodic match -> pending stays 1; reset_i pulsed mid-count -> all REQ-032 values.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared register map, control-bit positions and reset values
// for the timer bank and its compare channels.
package timer_bank_pkg;

   localparam logic [1:0] OFS_MTIME_LO = 2'd0;
   localparam logic [1:0] OFS_MTIME_HI = 2'd1;
   localparam logic [1:0] OFS_PRESCALE = 2'd2;
   localparam logic [1:0] OFS_CTRL     = 2'd3;

   localparam logic [1:0] OFS_CMP_LO   = 2'd0;
   localparam logic [1:0] OFS_CMP_HI   = 2'd1;
   localparam logic [1:0] OFS_RELOAD   = 2'd2;
   localparam logic [1:0] OFS_CHCTRL   = 2'd3;

   localparam int CTRL_EN     = 0;
   localparam int CH_EN       = 0;
   localparam int CH_PERIODIC = 1;
   localparam int CH_PENDING  = 2;

   localparam logic        CTRL_RST   = 1'b1;
   localparam logic [63:0] CMP_RST    = '1;
   localparam logic [31:0] RELOAD_RST = '0;

   function automatic logic [31:0] merge(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [3:0]  lanes
   );
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (lanes[b]) r[8*b +: 8] = wdata[8*b +: 8];
      return r;
   endfunction

endpackage

// File: rtl/timer_channel.sv
// One compare channel: cmp/reload/control registers, 64-bit
// compare, periodic reload and the registered interrupt level.
module timer_channel
   import timer_bank_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] mtime,
   input  logic        wr,
   input  logic [1:0]  sel,
   input  logic [31:0] data,
   input  logic [3:0]  lanes,
   output logic [63:0] cmp,
   output logic [31:0] reload,
   output logic [2:0]  chctrl,
   output logic        irq
);

   logic en;
   logic periodic;
   logic pending;
   logic match;
   logic hit;
   logic clr;
   logic pending_nxt;

   assign match = mtime >= cmp;
   assign hit   = en & periodic & match;
   assign clr   = wr & (sel == OFS_CHCTRL) & lanes[0] & data[CH_PENDING];

   // a match in the same cycle as a W1C wins
   assign pending_nxt = hit | (pending & ~clr);

   assign chctrl = {pending, periodic, en};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp      <= CMP_RST;
         reload   <= RELOAD_RST;
         en       <= 1'b0;
         periodic <= 1'b0;
         pending  <= 1'b0;
         irq      <= 1'b0;
      end else begin
         pending <= pending_nxt;
         irq     <= en & (periodic ? pending_nxt : match);
         if (wr && sel == OFS_CMP_LO)
            cmp[31:0] <= merge(cmp[31:0], data, lanes);
         else if (wr && sel == OFS_CMP_HI)
            cmp[63:32] <= merge(cmp[63:32], data, lanes);
         else if (hit)
            cmp <= cmp + {32'b0, reload};
         if (wr && sel == OFS_RELOAD)
            reload <= merge(reload, data, lanes);
         if (wr && sel == OFS_CHCTRL && lanes[0]) begin
            en       <= data[CH_EN];
            periodic <= data[CH_PERIODIC];
         end
      end
   end

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped 64-bit mtime with prescaler and a bank of
// compare channels; SRAM-style bus with registered read data.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter  int CHANNELS       = 4,
   parameter  int PRESCALE_WIDTH = 16,
   localparam int ADDR_WIDTH     = $clog2(16*(CHANNELS+1))
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  csb_i,
   input  logic                  wen_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           data_i,
   input  logic [3:0]            wmask_i,
   output logic [31:0]           data_o,
   output logic [CHANNELS-1:0]   irq_o
);

   localparam int PW = ADDR_WIDTH - 4;

   logic [PW-1:0]             page;
   logic [1:0]                sel;
   logic                      we;
   logic                      re;
   logic                      gwr;
   logic [63:0]               mtime;
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic [PRESCALE_WIDTH-1:0] count;
   logic                      count_en;
   logic                      tick;
   logic [31:0]               prescale_w;
   logic [31:0]               rdata;
   logic                      unused;

   logic [63:0] cmp    [CHANNELS];
   logic [31:0] reload [CHANNELS];
   logic [2:0]  chctrl [CHANNELS];

   assign page = addr_i[ADDR_WIDTH-1:4];
   assign sel  = addr_i[3:2];
   assign we   = ~csb_i & ~wen_i;
   assign re   = ~csb_i & wen_i;
   assign gwr  = we && page == '0;
   assign tick = count_en && count == prescale;

   assign prescale_w = merge(32'(prescale), data_i, wmask_i);
   assign unused     = ^{addr_i[1:0], prescale_w};

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         mtime    <= '0;
         count    <= '0;
         prescale <= '0;
         count_en <= CTRL_RST;
      end else begin
         if (gwr && sel == OFS_PRESCALE) begin
            prescale <= prescale_w[PRESCALE_WIDTH-1:0];
            count    <= '0;
         end else if (count_en) begin
            count <= tick ? '0 : count + PRESCALE_WIDTH'(1);
         end
         if (gwr && sel == OFS_CTRL && wmask_i[0])
            count_en <= data_i[CTRL_EN];
         // a software load replaces this cycle's increment, no carry
         if (gwr && sel == OFS_MTIME_LO)
            mtime[31:0] <= merge(mtime[31:0], data_i, wmask_i);
         else if (gwr && sel == OFS_MTIME_HI)
            mtime[63:32] <= merge(mtime[63:32], data_i, wmask_i);
         else if (tick)
            mtime <= mtime + 64'd1;
      end
   end

   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      timer_channel u_ch (
         .clk    (clk_i),
         .rst_n  (reset_i),
         .mtime  (mtime),
         .wr     (we && int'(page) == n + 1),
         .sel    (sel),
         .data   (data_i),
         .lanes  (wmask_i),
         .cmp    (cmp[n]),
         .reload (reload[n]),
         .chctrl (chctrl[n]),
         .irq    (irq_o[n])
      );
   end

   always_comb begin
      rdata = '0;
      if (page == '0) begin
         unique case (sel)
            OFS_MTIME_LO: rdata = mtime[31:0];
            OFS_MTIME_HI: rdata = mtime[63:32];
            OFS_PRESCALE: rdata = 32'(prescale);
            OFS_CTRL:     rdata = {31'b0, count_en};
         endcase
      end
      for (int n = 0; n < CHANNELS; n++) begin
         if (int'(page) == n + 1) begin
            unique case (sel)
               OFS_CMP_LO: rdata = cmp[n][31:0];
               OFS_CMP_HI: rdata = cmp[n][63:32];
               OFS_RELOAD: rdata = reload[n];
               OFS_CHCTRL: rdata = {29'b0, chctrl[n]};
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) data_o <= '0;
      else          data_o <= re ? rdata : '0;
   end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: register vector table plus
// hand-written sequences for prescaling, compare and reset.
module tb_timer_bank;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        csb_i;
   logic        wen_i;
   logic [6:0]  addr_i;
   logic [31:0] data_i;
   logic [3:0]  wmask_i;
   logic [31:0] data_o;
   logic [3:0]  irq_o;

   int n_checks = 0;
   int n_fail   = 0;

   timer_bank dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .csb_i   (csb_i),
      .wen_i   (wen_i),
      .addr_i  (addr_i),
      .data_i  (data_i),
      .wmask_i (wmask_i),
      .data_o  (data_o),
      .irq_o   (irq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        wr;
      logic [6:0]  addr;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic wr, input logic [6:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               input logic [31:0] e);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.mask = m; v.exp = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [31:0] d,
                     input logic [3:0] m);
      csb_i = 1'b0; wen_i = 1'b0; addr_i = a; data_i = d; wmask_i = m;
      @(negedge clk_i);
      csb_i = 1'b1; wen_i = 1'b1;
   endtask

   task automatic rd(input string name, input logic [6:0] a,
                     input logic [31:0] e);
      csb_i = 1'b0; wen_i = 1'b1; addr_i = a;
      @(negedge clk_i);
      check(name, data_o, e);
      csb_i = 1'b1;
   endtask

   task automatic reset_seq(input logic [6:0] inflight);
      csb_i = 1'b0; wen_i = 1'b0; addr_i = inflight;
      data_i = 32'h0; wmask_i = 4'hF;
      reset_i = 1'b0;
      @(posedge clk_i); #1;
      check("rst_data_o", data_o, 32'h0);
      check("rst_irq", 32'(irq_o), 32'h0);
      @(negedge clk_i);
      wen_i = 1'b1; addr_i = 7'h00; reset_i = 1'b1;
      @(negedge clk_i);
      check("rst_mtime_lo", data_o, 32'h0);
      csb_i = 1'b1;
      rd("rst_mtime_hi", 7'h04, 32'h0);
      rd("rst_ctrl",     7'h0C, 32'h1);
      rd("rst_prescale", 7'h08, 32'h0);
      rd("rst_cmp0_lo",  7'h10, 32'hFFFF_FFFF);
      rd("rst_cmp0_hi",  7'h14, 32'hFFFF_FFFF);
      rd("rst_reload0",  7'h18, 32'h0);
      rd("rst_chctrl0",  7'h1C, 32'h0);
      rd("rst_chctrl1",  7'h2C, 32'h0);
      check("rst_irq_after", 32'(irq_o), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i = 1'b0; csb_i = 1'b1; wen_i = 1'b1;
      addr_i = '0; data_i = '0; wmask_i = '0;

      reset_seq(7'h00);

      vecs.push_back(mk(1, 7'h0C, 32'h0,          4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h0C, 32'h0,          4'h0, 32'h0));
      vecs.push_back(mk(1, 7'h08, 32'h3,          4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h08, 32'h0,          4'h0, 32'h3));
      vecs.push_back(mk(1, 7'h08, 32'h1200,       4'h2, 32'h0));
      vecs.push_back(mk(0, 7'h08, 32'h0,          4'h0, 32'h1203));
      vecs.push_back(mk(1, 7'h08, 32'h0,          4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h08, 32'h0,          4'h0, 32'h0));
      vecs.push_back(mk(1, 7'h10, 32'h1234_5678,  4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h10, 32'h0,          4'h0, 32'h1234_5678));
      vecs.push_back(mk(1, 7'h14, 32'h0000_AB00,  4'h2, 32'h0));
      vecs.push_back(mk(0, 7'h14, 32'h0,          4'h0, 32'hFFFF_ABFF));
      vecs.push_back(mk(1, 7'h50, 32'hDEAD_BEEF,  4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h50, 32'h0,          4'h0, 32'h0));
      vecs.push_back(mk(0, 7'h10, 32'h0,          4'h0, 32'h1234_5678));
      vecs.push_back(mk(1, 7'h18, 32'h55,         4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h18, 32'h0,          4'h0, 32'h55));
      vecs.push_back(mk(1, 7'h00, 32'hFFFF_FFFF,  4'hF, 32'h0));
      vecs.push_back(mk(1, 7'h04, 32'h0,          4'hF, 32'h0));
      vecs.push_back(mk(1, 7'h0C, 32'h1,          4'hF, 32'h0));
      vecs.push_back(mk(1, 7'h0C, 32'h0,          4'hF, 32'h0));
      vecs.push_back(mk(0, 7'h04, 32'h0,          4'h0, 32'h1));
      vecs.push_back(mk(0, 7'h00, 32'h0,          4'h0, 32'h0));
      vecs.push_back(mk(1, 7'h00, 32'h0000_00AB,  4'h1, 32'h0));
      vecs.push_back(mk(0, 7'h00, 32'h0,          4'h0, 32'hAB));

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            wr(vecs[i].addr, vecs[i].data, vecs[i].mask);
            check($sformatf("vec%0d_wr", i), data_o, vecs[i].exp);
         end else begin
            rd($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
         end
      end

      // prescale 3: one tick every 4 counting cycles
      wr(7'h00, 32'h0, 4'hF);
      wr(7'h04, 32'h0, 4'hF);
      wr(7'h08, 32'h3, 4'hF);
      wr(7'h0C, 32'h1, 4'hF);
      repeat (40) @(negedge clk_i);
      wr(7'h0C, 32'h0, 4'hF);
      rd("prescale_mtime_lo", 7'h00, 32'd10);

      // one-shot channel 0
      wr(7'h08, 32'h0, 4'hF);
      wr(7'h00, 32'h0, 4'hF);
      wr(7'h10, 32'd20, 4'hF);
      wr(7'h14, 32'h0, 4'hF);
      wr(7'h1C, 32'h1, 4'hF);
      check("os_irq_idle", 32'(irq_o[0]), 32'h0);
      wr(7'h0C, 32'h1, 4'hF);
      repeat (19) @(negedge clk_i);
      check("os_irq_mtime19", 32'(irq_o[0]), 32'h0);
      @(negedge clk_i);
      check("os_irq_mtime20", 32'(irq_o[0]), 32'h0);
      @(negedge clk_i);
      check("os_irq_rise", 32'(irq_o[0]), 32'h1);
      wr(7'h0C, 32'h0, 4'hF);
      wr(7'h14, 32'h1, 4'hF);
      check("os_irq_hold", 32'(irq_o[0]), 32'h1);
      @(negedge clk_i);
      check("os_irq_fall", 32'(irq_o[0]), 32'h0);

      // periodic channel 1
      wr(7'h00, 32'h0, 4'hF);
      wr(7'h20, 32'd10, 4'hF);
      wr(7'h24, 32'h0, 4'hF);
      wr(7'h28, 32'd10, 4'hF);
      wr(7'h2C, 32'h3, 4'hF);
      wr(7'h0C, 32'h1, 4'hF);
      repeat (10) @(negedge clk_i);
      check("per_irq_before", 32'(irq_o[1]), 32'h0);
      wr(7'h0C, 32'h0, 4'hF);
      check("per_irq_set", 32'(irq_o[1]), 32'h1);
      rd("per_chctrl_pend", 7'h2C, 32'h7);
      rd("per_cmp_reload", 7'h20, 32'd20);
      wr(7'h2C, 32'h7, 4'h1);
      check("per_irq_w1c", 32'(irq_o[1]), 32'h0);
      rd("per_chctrl_clr", 7'h2C, 32'h3);
      wr(7'h00, 32'd19, 4'hF);
      wr(7'h0C, 32'h1, 4'hF);
      @(negedge clk_i);
      check("per_irq_pre20", 32'(irq_o[1]), 32'h0);
      @(negedge clk_i);
      check("per_irq_again", 32'(irq_o[1]), 32'h1);
      wr(7'h0C, 32'h0, 4'hF);

      // reload 0 and W1C on the same edge as a match
      wr(7'h28, 32'h0, 4'hF);
      wr(7'h2C, 32'h7, 4'h1);
      check("r0_irq_cleared", 32'(irq_o[1]), 32'h0);
      wr(7'h20, 32'd5, 4'hF);
      wr(7'h2C, 32'h7, 4'h1);
      check("r0_irq_set_wins", 32'(irq_o[1]), 32'h1);
      rd("r0_chctrl", 7'h2C, 32'h7);
      rd("r0_cmp_held", 7'h20, 32'd5);
      check("r0_irq_held", 32'(irq_o[1]), 32'h1);

      // reset mid-count with a write in flight
      wr(7'h08, 32'h3, 4'hF);
      wr(7'h0C, 32'h1, 4'hF);
      repeat (7) @(negedge clk_i);
      reset_seq(7'h10);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
